button_debouncer: RTL and testbench
===================================

// Module: button_debouncer
// PURPOSE
//   Conditions one raw pushbutton/switch input into a glitch-free level for the downstream rising-edge detector.
//   Stages: 2-flop synchroniser, then a free-running sample-tick divider, then a 4-state qualify FSM.
//   btn_clean changes only after the synchronised input has held a new level for STABLE_TICKS consecutive ticks.
// PARAMETERS
//   TICK_DIV      100000  clk cycles per sample tick (1 ms at 100 MHz); must be >= 2
//   STABLE_TICKS  10      consecutive ticks a new level must hold before btn_clean follows; must be >= 1
//   DIV_W         17      divider width; 2**DIV_W >= TICK_DIV
//   CNT_W         4       stability counter width; 2**CNT_W >= STABLE_TICKS
// PORTS
//   clk        in   1      system clock, all logic on posedge
//   rst        in   1      synchronous, active-high reset
//   btn_in     in   1      raw asynchronous button level
//   btn_clean  out  1      debounced level (Moore decode of state)
//   busy       out  1      1 while a level change is being qualified (S_RISE or S_FALL)
//   glitch_cnt out  8      rejected-transition count; present only with DEBOUNCE_STATUS_EN
// BEHAVIOUR
//   Reset (rst=1 at posedge) gives:
//     sync0=sync1=0, div=0, cnt=0, state=S_LOW.
//     btn_clean=0, busy=0, glitch_cnt=0 from the next cycle.
//   Synchroniser: sync0<=btn_in; sync1<=sync0. The FSM sees only sync1.
//   Divider: free-running and independent of FSM state.
//     div counts 0..TICK_DIV-1 and wraps to 0.
//     tick=1 (combinational) for exactly the one cycle in which div==TICK_DIV-1.
//   FSM states and outputs (btn_clean/busy):
//     S_LOW 0/0, S_RISE 0/1, S_HIGH 1/0, S_FALL 1/1.
//   S_LOW:  sync1=1 -> S_RISE with cnt<=0; otherwise stay.
//   S_RISE: the sync1=0 check has priority over tick in the same cycle.
//     sync1=0 -> S_LOW (glitch).
//     else tick & cnt==STABLE_TICKS-1 -> S_HIGH.
//     else tick -> cnt<=cnt+1.
//     else hold.
//   S_HIGH: sync1=0 -> S_FALL with cnt<=0; otherwise stay.
//   S_FALL: mirror of S_RISE.
//     sync1=1 -> S_HIGH (glitch).
//     else tick & cnt==STABLE_TICKS-1 -> S_LOW.
//     else tick -> cnt++.
//   Latency: let e0 be the first posedge that samples the new btn_in level.
//     btn_clean changes after edge e0+L, where (STABLE_TICKS-1)*TICK_DIV+3 <= L <= STABLE_TICKS*TICK_DIV+2.
//     The exact value depends on divider phase.
//   A glitch restarts qualification from zero: the next entry to S_RISE/S_FALL clears cnt.
//   Reset mid-qualification aborts it. If btn_in is still held, the full latency applies again from S_LOW.
//   The cnt increment never exceeds STABLE_TICKS-1, so it cannot wrap.
//   Unused state encodings recover to S_LOW on the next clock.
// CONFIGURATION
//   DEBOUNCE_STATUS_EN defined:
//     glitch_cnt port exists.
//     It increments by 1 on each S_RISE->S_LOW or S_FALL->S_HIGH transition.
//     It saturates at 8'hFF and is cleared only by rst.
//   DEBOUNCE_STATUS_EN undefined:
//     The port and its counter are absent; all other behaviour is identical.
// TESTING (bench uses TICK_DIV=4, STABLE_TICKS=3)
//   Reset: rst=1 for 2 cycles with btn_in=1 -> btn_clean=0 and busy=0 during reset.
//     After release, btn_clean=1 within 11..14 cycles.
//   Clean press: btn_in 0->1 held -> busy=1 from e0+2.
//     btn_clean=1 after exactly 11..14 edges from e0, and busy returns to 0 in the same cycle.
//   Bounce: btn_in toggles 1,0,1,0,1 with 3-cycle pulses, then holds 1.
//     btn_clean stays 0 through the bounce and rises 11..14 cycles after the final 0->1.
//     glitch_cnt=2 (macro on).
//   Release glitch: btn_clean=1, btn_in=0 for 5 cycles, then 1 -> btn_clean never drops.
//     FSM ends in S_HIGH; glitch_cnt +1.
//   Mid-op reset: rst=1 for 1 cycle while in S_RISE with btn_in held 1.
//     btn_clean=0, state=S_LOW; requalification takes the full 11..14 cycles.
//   Saturation (macro on): 300 single-cycle-wide 2-cycle glitches -> glitch_cnt=8'hFF, no wrap.

Source files
------------

// File: rtl/button_debouncer.sv
// button_debouncer: 2-flop synchroniser, free-running sample-tick divider and
// a 4-state qualify FSM producing a glitch-free button level.
// Optional build macro DEBOUNCE_STATUS_EN adds the saturating glitch_cnt port.
module button_debouncer #(
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned STABLE_TICKS = 10,
  parameter int unsigned DIV_W        = 17,
  parameter int unsigned CNT_W        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       btn_clean,
  output logic       busy
`ifdef DEBOUNCE_STATUS_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  typedef enum logic [1:0] {
    S_LOW  = 2'b00,
    S_RISE = 2'b01,
    S_HIGH = 2'b11,
    S_FALL = 2'b10
  } state_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic             sync0_q, sync1_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_t           state_q, state_d;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
    end else begin
      sync0_q <= btn_in;
      sync1_q <= sync0_q;
    end
  end

  // Free-running divider; tick marks its terminal count.
  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + 1'b1;
  end

  // Divider register.
  always_ff @(posedge clk) begin
    if (rst) div_q <= '0;
    else     div_q <= div_d;
  end

  // Qualify FSM next-state: a level mismatch always wins over a tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_LOW: begin
        if (sync1_q) begin
          state_d = S_RISE;
          cnt_d   = '0;
        end
      end
      S_RISE: begin
        if (!sync1_q) begin
          state_d = S_LOW;
        end else if (tick) begin
          if (cnt_q == CNT_LAST) state_d = S_HIGH;
          else                   cnt_d   = cnt_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (!sync1_q) begin
          state_d = S_FALL;
          cnt_d   = '0;
        end
      end
      S_FALL: begin
        if (sync1_q) begin
          state_d = S_HIGH;
        end else if (tick) begin
          if (cnt_q == CNT_LAST) state_d = S_LOW;
          else                   cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = S_LOW;
    endcase
  end

  // FSM state and stability counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore output decode.
  always_comb begin
    btn_clean = (state_q == S_HIGH) || (state_q == S_FALL);
    busy      = (state_q == S_RISE) || (state_q == S_FALL);
  end

`ifdef DEBOUNCE_STATUS_EN
  logic       glitch_evt;
  logic [7:0] glitch_q, glitch_d;

  // A rejected transition is an aborted qualification back to the old level.
  always_comb begin
    glitch_evt = ((state_q == S_RISE) && (state_d == S_LOW)) ||
                 ((state_q == S_FALL) && (state_d == S_HIGH));
    glitch_d   = (glitch_evt && (glitch_q != 8'hFF)) ? glitch_q + 8'd1 : glitch_q;
  end

  // Saturating rejected-transition counter, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) glitch_q <= '0;
    else     glitch_q <= glitch_d;
  end

  assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer (TICK_DIV=4, STABLE_TICKS=3).
// Reference model: the clean level flips once the synchronised input has
// disagreed with it continuously and STABLE_TICKS sample ticks have elapsed
// after the first disagreeing cycle; a broken disagreement run is a glitch.
module tb_button_debouncer;

  localparam int TD = 4;
  localparam int ST = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b0;
  logic btn_clean, busy;
`ifdef DEBOUNCE_STATUS_EN
  logic [7:0] glitch_cnt;
`endif

  int vectors = 0;
  int errors  = 0;

  button_debouncer #(
    .TICK_DIV(4),
    .STABLE_TICKS(3),
    .DIV_W(3),
    .CNT_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .btn_clean(btn_clean),
    .busy(busy)
`ifdef DEBOUNCE_STATUS_EN
    ,
    .glitch_cnt(glitch_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic m_s0 = 1'b0, m_s1 = 1'b0;
  logic m_clean = 1'b0, m_run = 1'b0;
  int   m_phase = 0, m_ticks = 0, m_glitch = 0;

  always @(posedge clk) begin
    logic tk;
    if (rst) begin
      m_s0 = 1'b0; m_s1 = 1'b0; m_phase = 0;
      m_clean = 1'b0; m_run = 1'b0; m_ticks = 0; m_glitch = 0;
    end else begin
      tk = (m_phase == TD - 1);
      if (m_s1 != m_clean) begin
        if (!m_run) begin
          m_run = 1'b1;
          m_ticks = 0;
        end else if (tk) begin
          m_ticks++;
          if (m_ticks == ST) begin
            m_clean = ~m_clean;
            m_run = 1'b0;
          end
        end
      end else begin
        if (m_run && m_glitch < 255) m_glitch++;
        m_run = 1'b0;
      end
      m_phase = (m_phase + 1) % TD;
      m_s1 = m_s0;
      m_s0 = btn_in;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, vectors=%0d", vectors);
    $fatal(1);
  end

  // ---------------- scenarios ----------------
  task automatic settle_low(input int n);
    btn_in = 1'b0;
    repeat (n) @(negedge clk);
    if (btn_clean !== 1'b0) begin
      $display("FAIL settle_low: btn_clean=%b required 0", btn_clean); errors++;
    end
    vectors++;
  endtask

  task automatic test_reset();
    int lat = -1;
    rst = 1'b1; btn_in = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (btn_clean !== 1'b0 || busy !== 1'b0) begin
        $display("FAIL reset_hold: clean=%b busy=%b required 0/0", btn_clean, busy); errors++;
      end
      vectors++;
`ifdef DEBOUNCE_STATUS_EN
      if (glitch_cnt !== 8'd0) begin
        $display("FAIL reset_glitch: glitch_cnt=%0d required 0", glitch_cnt); errors++;
      end
      vectors++;
`endif
    end
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (btn_clean !== m_clean || busy !== m_run) begin
        $display("FAIL reset_model k=%0d: clean=%b busy=%b required %b/%b", k, btn_clean, busy, m_clean, m_run); errors++;
      end
      vectors++;
      if (btn_clean === 1'b1 && lat < 0) lat = k;
    end
    if (lat < 11 || lat > 14) begin
      $display("FAIL reset_latency: latency=%0d required 11..14", lat); errors++;
    end
    vectors++;
  endtask

  task automatic test_clean_press();
    for (int it = 0; it < 6; it++) begin
      int lat = -1;
      settle_low(20);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      btn_in = 1'b1;
      for (int k = 0; k < 25; k++) begin
        @(negedge clk);
        if (btn_clean !== m_clean || busy !== m_run) begin
          $display("FAIL press_model k=%0d: clean=%b busy=%b required %b/%b", k, btn_clean, busy, m_clean, m_run); errors++;
        end
        vectors++;
        if (lat < 0) begin
          if (btn_clean === 1'b1) begin
            lat = k;
            if (busy !== 1'b0) begin
              $display("FAIL press_busy_drop: busy=%b required 0", busy); errors++;
            end
            vectors++;
          end else if (busy !== (k >= 2)) begin
            $display("FAIL press_busy k=%0d: busy=%b required %b", k, busy, (k >= 2)); errors++;
          end
        end
      end
      if (lat < 11 || lat > 14) begin
        $display("FAIL press_latency: latency=%0d required 11..14", lat); errors++;
      end
      vectors++;
    end
  endtask

  task automatic test_bounce();
    int lat = -1;
    int g0 = m_glitch;
    settle_low(20);
`ifdef DEBOUNCE_STATUS_EN
    g0 = glitch_cnt;
`endif
    for (int p = 0; p < 4; p++) begin
      btn_in = (p % 2 == 0);
      repeat (3) begin
        @(negedge clk);
        if (btn_clean !== 1'b0 || busy !== m_run) begin
          $display("FAIL bounce_hold: clean=%b busy=%b required 0/%b", btn_clean, busy, m_run); errors++;
        end
        vectors++;
      end
    end
    btn_in = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (btn_clean !== m_clean) begin
        $display("FAIL bounce_model k=%0d: clean=%b required %b", k, btn_clean, m_clean); errors++;
      end
      vectors++;
      if (btn_clean === 1'b1 && lat < 0) lat = k;
    end
    if (lat < 11 || lat > 14) begin
      $display("FAIL bounce_latency: latency=%0d required 11..14", lat); errors++;
    end
    vectors++;
`ifdef DEBOUNCE_STATUS_EN
    if (int'(glitch_cnt) !== g0 + 2) begin
      $display("FAIL bounce_glitches: glitch_cnt=%0d required %0d", glitch_cnt, g0 + 2); errors++;
    end
    vectors++;
`endif
  endtask

  task automatic test_release_glitch();
    int g0 = m_glitch;
`ifdef DEBOUNCE_STATUS_EN
    g0 = glitch_cnt;
`endif
    btn_in = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (k == 5) btn_in = 1'b1;
      @(negedge clk);
      if (btn_clean !== 1'b1) begin
        $display("FAIL release_glitch_hold k=%0d: clean=%b required 1", k, btn_clean); errors++;
      end
      vectors++;
    end
    if (busy !== 1'b0) begin
      $display("FAIL release_glitch_idle: busy=%b required 0", busy); errors++;
    end
    vectors++;
`ifdef DEBOUNCE_STATUS_EN
    if (int'(glitch_cnt) !== g0 + 1) begin
      $display("FAIL release_glitches: glitch_cnt=%0d required %0d", glitch_cnt, g0 + 1); errors++;
    end
    vectors++;
`endif
  endtask

  task automatic test_midop_reset();
    int lat = -1;
    settle_low(20);
    btn_in = 1'b1;
    repeat (4) @(negedge clk);
    if (busy !== 1'b1 || btn_clean !== 1'b0) begin
      $display("FAIL midop_qualifying: clean=%b busy=%b required 0/1", btn_clean, busy); errors++;
    end
    vectors++;
    rst = 1'b1;
    @(negedge clk);
    if (busy !== 1'b0 || btn_clean !== 1'b0) begin
      $display("FAIL midop_reset: clean=%b busy=%b required 0/0", btn_clean, busy); errors++;
    end
    vectors++;
    rst = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (btn_clean !== m_clean || busy !== m_run) begin
        $display("FAIL midop_model k=%0d: clean=%b busy=%b required %b/%b", k, btn_clean, busy, m_clean, m_run); errors++;
      end
      vectors++;
      if (btn_clean === 1'b1 && lat < 0) lat = k;
    end
    if (lat < 11 || lat > 14) begin
      $display("FAIL midop_latency: latency=%0d required 11..14", lat); errors++;
    end
    vectors++;
  endtask

  task automatic test_random();
    int left = 0;
    for (int c = 0; c < 400; c++) begin
      if (left == 0) begin
        btn_in = $urandom_range(0, 1);
        left = $urandom_range(1, 16);
      end
      left--;
      @(negedge clk);
      if (btn_clean !== m_clean || busy !== m_run) begin
        $display("FAIL random_model c=%0d: clean=%b busy=%b required %b/%b", c, btn_clean, busy, m_clean, m_run); errors++;
      end
      vectors++;
`ifdef DEBOUNCE_STATUS_EN
      if (int'(glitch_cnt) !== m_glitch) begin
        $display("FAIL random_glitch c=%0d: glitch_cnt=%0d required %0d", c, glitch_cnt, m_glitch); errors++;
      end
      vectors++;
`endif
    end
  endtask

`ifdef DEBOUNCE_STATUS_EN
  task automatic test_saturation();
    settle_low(20);
    for (int g = 0; g < 300; g++) begin
      btn_in = 1'b1;
      @(negedge clk);
      btn_in = 1'b0;
      repeat (2) @(negedge clk);
      if (int'(glitch_cnt) !== m_glitch) begin
        $display("FAIL sat_track g=%0d: glitch_cnt=%0d required %0d", g, glitch_cnt, m_glitch); errors++;
      end
      vectors++;
    end
    repeat (3) @(negedge clk);
    if (glitch_cnt !== 8'hFF || btn_clean !== 1'b0) begin
      $display("FAIL sat_final: glitch_cnt=%0h clean=%b required ff/0", glitch_cnt, btn_clean); errors++;
    end
    vectors++;
  endtask
`endif

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    test_midop_reset();
    test_random();
`ifdef DEBOUNCE_STATUS_EN
    test_saturation();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
